// File: rtl/axil_cfg_sequencer.sv
// AXI-Lite master that replays an (address, data) table into a slave, one write at a time.
// Optional read-back verify of each entry is built when AXIL_CFG_VERIFY_EN is defined.
module axil_cfg_sequencer #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int idx_width  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [idx_width-1:0]    num_entries,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [idx_width-1:0]    err_idx,
    output logic [idx_width-1:0]    tbl_idx,
    input  logic [addr_width-1:0]   tbl_addr,
    input  logic [data_width-1:0]   tbl_data,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [addr_width-1:0]   m_axi_awaddr,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [data_width-1:0]   m_axi_wdata,
    output logic [data_width/8-1:0] m_axi_wstrb,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    output logic [addr_width-1:0]   m_axi_araddr,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    input  logic [data_width-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WRITE = 3'd2,
        WRESP = 3'd3,
        RADDR = 3'd4,
        RDATA = 3'd5
    } state_t;

    localparam logic [idx_width-1:0] IDX_ONE = {{(idx_width-1){1'b0}}, 1'b1};

    if ((data_width % 8) != 0) begin : g_bad_data_width
        $error("axil_cfg_sequencer: data_width must be a multiple of 8");
    end

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [idx_width-1:0]    err_idx_q, err_idx_d;
    logic [idx_width-1:0]    tbl_idx_q, tbl_idx_d;
    logic [idx_width-1:0]    num_q, num_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [addr_width-1:0]   awaddr_q, awaddr_d;
    logic [data_width-1:0]   wdata_q, wdata_d;

    logic aw_hs_s, w_hs_s, b_hs_s, adv_s, last_s;

`ifdef AXIL_CFG_VERIFY_EN
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [addr_width-1:0]   araddr_q, araddr_d;
    logic                    ar_hs_s, r_hs_s;
`else
    logic                    unused_rd_s;
    assign unused_rd_s = ^{m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp};
`endif

    assign aw_hs_s = awvalid_q && m_axi_awready;
    assign w_hs_s  = wvalid_q && m_axi_wready;
    assign b_hs_s  = bready_q && m_axi_bvalid;
    assign last_s  = (tbl_idx_q == (num_q - IDX_ONE));
`ifdef AXIL_CFG_VERIFY_EN
    assign ar_hs_s = arvalid_q && m_axi_arready;
    assign r_hs_s  = rready_q && m_axi_rvalid;
`endif

    // Next-state and next-output computation for the sequencer FSM
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        tbl_idx_d = tbl_idx_q;
        num_d     = num_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        adv_s     = 1'b0;
`ifdef AXIL_CFG_VERIFY_EN
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (num_entries != {idx_width{1'b0}}) begin
                        num_d     = num_entries;
                        tbl_idx_d = {idx_width{1'b0}};
                        state_d   = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                awaddr_d  = tbl_addr;
                wdata_d   = tbl_data;
`ifdef AXIL_CFG_VERIFY_EN
                araddr_d  = tbl_addr;
`endif
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = WRITE;
            end
            WRITE: begin
                if (aw_hs_s) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else begin
                    w_done_d = w_done_q;
                end
                if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end else begin
                    state_d = WRITE;
                end
            end
            WRESP: begin
                if (b_hs_s) begin
                    bready_d = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        error_d   = 1'b1;
                        err_idx_d = tbl_idx_q;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
`ifdef AXIL_CFG_VERIFY_EN
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
`else
                        adv_s = 1'b1;
`endif
                    end
                end else begin
                    state_d = WRESP;
                end
            end
`ifdef AXIL_CFG_VERIFY_EN
            RADDR: begin
                if (ar_hs_s) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end else begin
                    state_d = RADDR;
                end
            end
            RDATA: begin
                if (r_hs_s) begin
                    rready_d = 1'b0;
                    if ((m_axi_rresp != 2'b00) || (m_axi_rdata != wdata_q)) begin
                        error_d   = 1'b1;
                        err_idx_d = tbl_idx_q;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    state_d = RDATA;
                end
            end
`endif
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
`ifdef AXIL_CFG_VERIFY_EN
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
`endif
            end
        endcase

        // Entry completed cleanly: finish the table or move on to the next index
        if (adv_s) begin
            if (last_s) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                tbl_idx_d = tbl_idx_q + IDX_ONE;
                state_d   = FETCH;
            end
        end else begin
            tbl_idx_d = tbl_idx_d;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= {idx_width{1'b0}};
            tbl_idx_q <= {idx_width{1'b0}};
            num_q     <= {idx_width{1'b0}};
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= {addr_width{1'b0}};
            wdata_q   <= {data_width{1'b0}};
`ifdef AXIL_CFG_VERIFY_EN
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= {addr_width{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            tbl_idx_q <= tbl_idx_d;
            num_q     <= num_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
`ifdef AXIL_CFG_VERIFY_EN
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_idx       = err_idx_q;
    assign tbl_idx       = tbl_idx_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = {(data_width/8){1'b1}};
    assign m_axi_bready  = bready_q;
`ifdef AXIL_CFG_VERIFY_EN
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_rready  = rready_q;
`else
    assign m_axi_arvalid = 1'b0;
    assign m_axi_araddr  = {addr_width{1'b0}};
    assign m_axi_rready  = 1'b1;
`endif

endmodule
